// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if -- bundle of every bus signal around the RAM arbiter.
//
// Signals:
//   cpu_*  : CPU request (req, we, addr, wdata) and response (gnt, rvalid, rdata)
//   dbg_*  : debug/loader request and response, same shape as the CPU port
//   ram_*  : single-port RAM side (wr_sig, wr_data, addr out; rd_data in,
//            valid one cycle after the address is presented)
//
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus the RAM)
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              ram_wr_sig;
    logic [DATA_W-1:0] ram_wr_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output ram_wr_sig, ram_wr_data, ram_addr,
        input  ram_rd_data
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ram_wr_sig, ram_wr_data, ram_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter -- two-port (CPU, debug/loader) arbiter in front of a single
// RAM with one-cycle read latency.
//
// Ports:
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : ram_arbiter_if.slave carrying the CPU, debug and RAM signals
//
// Grants are combinational from the requests. The CPU wins contention until
// it has taken MAX_CPU_RUN consecutive contested grants; the debug port is
// then served once. A small FSM remembers which port issued the read so
// that the RAM data returned next cycle is routed to that port only.
module ram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);

    localparam int RUN_W = (MAX_CPU_RUN < 1) ? 1 : $clog2(MAX_CPU_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_CPU_RUN);

    typedef enum logic [1:0] {
        IDLE,
        RD_CPU,
        RD_DBG
    } rd_state_e;

    rd_state_e         state_q, state_d;
    logic [RUN_W-1:0]  cpu_run_q, cpu_run_d;

    logic              cpu_gnt, dbg_gnt;
    logic              ram_wr_sig;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              cpu_rvalid, dbg_rvalid;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;

    // Grant decision, contested-run counter and RAM request mux
    always_comb begin
        cpu_gnt     = 1'b0;
        dbg_gnt     = 1'b0;
        cpu_run_d   = cpu_run_q;
        ram_wr_sig  = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;

        if (!reset) begin
            if (bus.cpu_req && bus.dbg_req) begin
                // Contested: debug only gets in once the CPU run is spent
                if (cpu_run_q == RUN_MAX) begin
                    dbg_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else if (bus.cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end

        // The run only counts CPU grants taken while debug is waiting;
        // any cycle without a debug request restarts it.
        if (!bus.dbg_req || dbg_gnt) begin
            cpu_run_d = '0;
        end else if (cpu_gnt && cpu_run_q != RUN_MAX) begin
            cpu_run_d = cpu_run_q + RUN_W'(1);
        end

        if (cpu_gnt) begin
            ram_wr_sig  = bus.cpu_we;
            ram_addr    = bus.cpu_addr;
            ram_wr_data = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            ram_wr_sig  = bus.dbg_we;
            ram_addr    = bus.dbg_addr;
            ram_wr_data = bus.dbg_wdata;
        end
    end

    // Pending-read FSM: next state depends only on this cycle's read grant
    always_comb begin
        state_d    = IDLE;
        cpu_rvalid = 1'b0;
        dbg_rvalid = 1'b0;
        cpu_rdata  = '0;
        dbg_rdata  = '0;

        if (cpu_gnt && !bus.cpu_we) begin
            state_d = RD_CPU;
        end else if (dbg_gnt && !bus.dbg_we) begin
            state_d = RD_DBG;
        end

        case (state_q)
            RD_CPU: begin
                cpu_rvalid = 1'b1;
                cpu_rdata  = bus.ram_rd_data;
            end
            RD_DBG: begin
                dbg_rvalid = 1'b1;
                dbg_rdata  = bus.ram_rd_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cpu_run_q <= '0;
        end else begin
            state_q   <= state_d;
            cpu_run_q <= cpu_run_d;
        end
    end

    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.cpu_rvalid  = cpu_rvalid;
    assign bus.cpu_rdata   = cpu_rdata;
    assign bus.dbg_rvalid  = dbg_rvalid;
    assign bus.dbg_rdata   = dbg_rdata;
    assign bus.ram_wr_sig  = ram_wr_sig;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wr_data = ram_wr_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter -- directed self-checking bench for ram_arbiter with a
// one-cycle-latency read-before-write RAM model.
module tb_ram_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_CPU_RUN(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // RAM model: registered read of the old contents, write at the same edge
    logic [31:0] mem [256];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        rd_q <= mem[bus.ram_addr[7:0]];
        if (bus.ram_wr_sig) mem[bus.ram_addr[7:0]] <= bus.ram_wr_data;
    end
    assign bus.ram_rd_data = rd_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic drive_dbg(input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.dbg_req   = req;
        bus.dbg_we    = we;
        bus.dbg_addr  = addr;
        bus.dbg_wdata = wdata;
    endtask

    task automatic idle_inputs();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Loader write through the debug port (one cycle, then idle)
    task automatic dbg_load(input logic [31:0] addr, input logic [31:0] data);
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b1, 1'b1, addr, data);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_cpu(1'b1, 1'b1, 32'h44, 32'h12345678);
        drive_dbg(1'b1, 1'b1, 32'h48, 32'h9ABCDEF0);
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_gnt, bus.dbg_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b want 00", {bus.cpu_gnt, bus.dbg_gnt});
        end
        n_checks++;
        if ({bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data} !== 65'h0) begin
            n_fail++; $display("FAIL reset_ram: wr=%b addr=%h data=%h want all 0",
                               bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data);
        end
        n_checks++;
        if ({bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata} !== 66'h0) begin
            n_fail++; $display("FAIL reset_rsp: rv=%b%b rdata=%h/%h want all 0",
                               bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        @(negedge clk);
        n_checks++;
        if ({bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.cpu_gnt, bus.dbg_gnt} !== 67'h0) begin
            n_fail++; $display("FAIL idle_ram: wr=%b addr=%h data=%h gnt=%b%b want all 0",
                               bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data, bus.cpu_gnt, bus.dbg_gnt);
        end
        tick();
    endtask

    task automatic test_cpu_read();
        dbg_load(32'h10, 32'hDEADBEEF);
        drive_cpu(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wr_sig} !== 3'b100 || bus.ram_addr !== 32'h10) begin
            n_fail++; $display("FAIL cpu_rd_gnt: gnt=%b%b wr=%b addr=%h want 10 0 00000010",
                               bus.cpu_gnt, bus.dbg_gnt, bus.ram_wr_sig, bus.ram_addr);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'hDEADBEEF || bus.dbg_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL cpu_rd_data: rv=%b data=%h dbg_rv=%b want 1 deadbeef 0",
                               bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_rvalid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 32'h0) begin
            n_fail++; $display("FAIL cpu_rd_done: rv=%b data=%h want 0 0", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp [10];
        exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 10; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
            drive_dbg(1'b1, 1'b0, 32'h8, 32'h0);
            @(negedge clk);
            n_checks++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== exp[i]) begin
                n_fail++; $display("FAIL contend[%0d]: gnt=%b want %b", i, {bus.cpu_gnt, bus.dbg_gnt}, exp[i]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_write_then_read();
        drive_dbg(1'b1, 1'b1, 32'h0, 32'h00000013);
        @(negedge clk);
        n_checks++;
        if (bus.dbg_gnt !== 1'b1 || bus.ram_wr_sig !== 1'b1 || bus.ram_wr_data !== 32'h13) begin
            n_fail++; $display("FAIL dbg_wr: gnt=%b wr=%b data=%h want 1 1 00000013",
                               bus.dbg_gnt, bus.ram_wr_sig, bus.ram_wr_data);
        end
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        drive_cpu(1'b1, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.cpu_gnt !== 1'b1 || bus.dbg_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_rd_gnt: cpu_gnt=%b dbg_rv=%b want 1 0", bus.cpu_gnt, bus.dbg_rvalid);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h13) begin
            n_fail++; $display("FAIL wr_rd_data: rv=%b data=%h want 1 00000013", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp [5];
        exp = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        dbg_load(32'h30, 32'h30303030);
        for (int i = 0; i < 2; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
            drive_dbg(1'b1, 1'b0, 32'h8, 32'h0);
            tick();
        end
        reset = 1'b1;
        drive_cpu(1'b1, 1'b1, 32'h30, 32'h0000005A);
        drive_dbg(1'b1, 1'b1, 32'h30, 32'h000000A5);
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_gnt, bus.dbg_gnt, bus.ram_wr_sig} !== 3'b000 || bus.ram_addr !== 32'h0
            || bus.ram_wr_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: gnt=%b%b wr=%b addr=%h data=%h want all 0",
                               bus.cpu_gnt, bus.dbg_gnt, bus.ram_wr_sig, bus.ram_addr, bus.ram_wr_data);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
            drive_dbg(1'b1, 1'b0, 32'h8, 32'h0);
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b00 || bus.cpu_rdata !== 32'h0) begin
                    n_fail++; $display("FAIL post_reset_rv: rv=%b%b data=%h want 00 0",
                                       bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata);
                end
            end
            n_checks++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== exp[i]) begin
                n_fail++; $display("FAIL post_reset_run[%0d]: gnt=%b want %b", i, {bus.cpu_gnt, bus.dbg_gnt}, exp[i]);
            end
            tick();
        end
        // Confirm nothing was written while reset was high
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        drive_cpu(1'b1, 1'b0, 32'h30, 32'h0);
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h30303030) begin
            n_fail++; $display("FAIL reset_no_write: rv=%b data=%h want 1 30303030", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    task automatic test_dbg_drop();
        logic [1:0] exp [9];
        logic       dreq [9];
        exp  = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        dreq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
            drive_dbg(dreq[i], 1'b0, 32'h8, 32'h0);
            @(negedge clk);
            n_checks++;
            if ({bus.cpu_gnt, bus.dbg_gnt} !== exp[i]) begin
                n_fail++; $display("FAIL dbg_drop[%0d]: gnt=%b want %b", i, {bus.cpu_gnt, bus.dbg_gnt}, exp[i]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_alternate();
        dbg_load(32'h4, 32'hAAAA0004);
        dbg_load(32'h8, 32'hBBBB0008);
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            if (i < 6) begin
                if (i % 2 == 0) drive_cpu(1'b1, 1'b0, 32'h4, 32'h0);
                else            drive_dbg(1'b1, 1'b0, 32'h8, 32'h0);
            end
            @(negedge clk);
            if (i < 6) begin
                n_checks++;
                if ({bus.cpu_gnt, bus.dbg_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL alt_gnt[%0d]: gnt=%b", i, {bus.cpu_gnt, bus.dbg_gnt});
                end
            end
            if (i > 0) begin
                n_checks++;
                if (i % 2 == 1) begin
                    if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b10 || bus.cpu_rdata !== 32'hAAAA0004
                        || bus.dbg_rdata !== 32'h0) begin
                        n_fail++; $display("FAIL alt_rsp[%0d]: rv=%b%b cpu=%h dbg=%h want 10 aaaa0004 0",
                                           i, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata);
                    end
                end else begin
                    if ({bus.cpu_rvalid, bus.dbg_rvalid} !== 2'b01 || bus.dbg_rdata !== 32'hBBBB0008
                        || bus.cpu_rdata !== 32'h0) begin
                        n_fail++; $display("FAIL alt_rsp[%0d]: rv=%b%b cpu=%h dbg=%h want 01 0 bbbb0008",
                                           i, bus.cpu_rvalid, bus.dbg_rvalid, bus.cpu_rdata, bus.dbg_rdata);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_read_before_write();
        dbg_load(32'h20, 32'h11111111);
        drive_cpu(1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        drive_cpu(1'b0, 1'b0, 32'h0, 32'h0);
        drive_dbg(1'b1, 1'b1, 32'h20, 32'h22222222);
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h11111111 || bus.dbg_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rbw_old: rv=%b data=%h dbg_gnt=%b want 1 11111111 1",
                               bus.cpu_rvalid, bus.cpu_rdata, bus.dbg_gnt);
        end
        tick();
        drive_dbg(1'b0, 1'b0, 32'h0, 32'h0);
        drive_cpu(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        n_checks++;
        if (bus.dbg_rvalid !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rbw_wr_norv: dbg_rv=%b data=%h want 0 0", bus.dbg_rvalid, bus.dbg_rdata);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h22222222) begin
            n_fail++; $display("FAIL rbw_new: rv=%b data=%h want 1 22222222", bus.cpu_rvalid, bus.cpu_rdata);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_cpu_read();
        test_contention();
        test_write_then_read();
        test_reset_mid();
        test_dbg_drop();
        test_alternate();
        test_read_before_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
